// File: rtl/counter_mode_decoder.sv
// counter_mode_decoder: recovers step/direction of an up/down counter from its sampled output.
// Latency: outputs are registered and reflect samples taken up to the last rising clk edge.
// Backpressure: none; sample=0 holds all state and clears the err/mode_change pulses.
//
// Optional feature macro: COUNTER_MODE_DECODER_MODE_CHANGE_EN
//   When it is defined, a legal but different delta seen while locked switches
//   the mode in place and pulses mode_change instead of raising err.
//
// Ports:
//   clk, nrst          clock (rising edge), asynchronous active-low reset
//   sample, count      count is valid when sample=1
//   step, down         recovered mode (step: 0 = by 1, 1 = by 2; down: 1 = counting down)
//   locked             step/down are trusted
//   err                one-cycle pulse on a sequence violation while locked
//   mode_change        one-cycle pulse on an in-place mode switch (optional feature)
//   err_cnt            saturating count of err pulses
module counter_mode_decoder #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             sample,
  input  logic [WIDTH-1:0] count,
  output logic             step,
  output logic             down,
  output logic             locked,
  output logic             err,
  output logic             mode_change,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_t;

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [WIDTH-1:0] UP1 = WIDTH'(1);
  localparam logic [WIDTH-1:0] UP2 = WIDTH'(2);
  localparam logic [WIDTH-1:0] DN1 = '1;
  localparam logic [WIDTH-1:0] DN2 = DN1 - UP1;

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic             cand_vld_q;
  logic [1:0]       cand_q;      // {step, down}
  logic [RUN_W-1:0] run_q;
  logic             step_q;
  logic             down_q;
  logic             locked_q;
  logic             err_q;
  logic             mc_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [WIDTH-1:0] delta;
  logic             legal;
  logic [1:0]       code;        // {step, down} implied by delta
  logic [RUN_W-1:0] run_d;       // run length after this delta while acquiring

  // Subtraction wraps naturally, so counter roll-over is just another legal delta.
  always_comb begin
    delta = count - prev_q;
    legal = 1'b1;
    code  = 2'b00;
    case (delta)
      UP1:     code = 2'b00;
      UP2:     code = 2'b10;
      DN1:     code = 2'b01;
      DN2:     code = 2'b11;
      default: legal = 1'b0;
    endcase
    if (cand_vld_q && cand_q == code) run_d = run_q + RUN_W'(1);
    else                              run_d = RUN_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= EMPTY;
      prev_q     <= '0;
      cand_vld_q <= 1'b0;
      cand_q     <= 2'b00;
      run_q      <= '0;
      step_q     <= 1'b0;
      down_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      mc_q       <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_q <= 1'b0;
      mc_q  <= 1'b0;
      if (sample) begin
        prev_q <= count;
        case (state_q)
          EMPTY: begin
            state_q    <= ACQ;
            cand_vld_q <= 1'b0;
            run_q      <= '0;
          end
          ACQ: begin
            if (!legal) begin
              cand_vld_q <= 1'b0;
              run_q      <= '0;
            end else begin
              cand_vld_q <= 1'b1;
              cand_q     <= code;
              run_q      <= run_d;
              if (run_d == RUN_W'(LOCK_N)) begin
                state_q  <= LOCKED;
                step_q   <= code[1];
                down_q   <= code[0];
                locked_q <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (legal && code == {step_q, down_q}) begin
              // consistent with the locked mode: nothing to do
            end
`ifdef COUNTER_MODE_DECODER_MODE_CHANGE_EN
            else if (legal) begin
              step_q <= code[1];
              down_q <= code[0];
              mc_q   <= 1'b1;
            end
`endif
            else begin
              // Drop lock but keep step/down; a legal delta seeds the new run.
              err_q      <= 1'b1;
              locked_q   <= 1'b0;
              state_q    <= ACQ;
              cand_vld_q <= legal;
              cand_q     <= code;
              run_q      <= legal ? RUN_W'(1) : '0;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign step        = step_q;
  assign down        = down_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign mode_change = mc_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_counter_mode_decoder.sv
// Directed bench for counter_mode_decoder: instance a uses default parameters,
// instance b shares the stimulus with ERR_W = 2 to exercise saturation.
module tb_counter_mode_decoder;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       sample = 1'b0;
  logic [3:0] count = 4'd0;

  logic       a_step, a_down, a_locked, a_err, a_mc;
  logic [7:0] a_cnt;
  logic       b_step, b_down, b_locked, b_err, b_mc;
  logic [1:0] b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef COUNTER_MODE_DECODER_MODE_CHANGE_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  counter_mode_decoder #(.WIDTH(4), .LOCK_N(3), .ERR_W(8)) u_a (
    .clk(clk), .nrst(nrst), .sample(sample), .count(count),
    .step(a_step), .down(a_down), .locked(a_locked), .err(a_err),
    .mode_change(a_mc), .err_cnt(a_cnt)
  );

  counter_mode_decoder #(.WIDTH(4), .LOCK_N(3), .ERR_W(2)) u_b (
    .clk(clk), .nrst(nrst), .sample(sample), .count(count),
    .step(b_step), .down(b_down), .locked(b_locked), .err(b_err),
    .mode_change(b_mc), .err_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Checks every output of instance a.
  task automatic chk_a(input string tag, input logic es, input logic ed, input logic el,
                       input logic ee, input logic em, input logic [7:0] ec);
    chk({tag, ".step"},   32'(a_step),   32'(es));
    chk({tag, ".down"},   32'(a_down),   32'(ed));
    chk({tag, ".locked"}, 32'(a_locked), 32'(el));
    chk({tag, ".err"},    32'(a_err),    32'(ee));
    chk({tag, ".mc"},     32'(a_mc),     32'(em));
    chk({tag, ".cnt"},    32'(a_cnt),    32'(ec));
  endtask

  // Called at a falling edge: presents one sample for exactly one rising edge.
  task automatic smp(input logic [3:0] v);
    sample = 1'b1;
    count  = v;
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [3:0] p;

    // Reset values
    #1;
    chk_a("rst", 0, 0, 0, 0, 0, 8'd0);
    chk("rst.b_cnt", 32'(b_cnt), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Up by one: locks on the 4th sample
    smp(4'd0); smp(4'd1); smp(4'd2);
    chk("up1.pre", 32'(a_locked), 32'd0);
    smp(4'd3);
    chk_a("up1", 0, 0, 1, 0, 0, 8'd0);

    // Up by two across the wrap
    do_reset();
    smp(4'd12); smp(4'd14); smp(4'd0); smp(4'd2);
    chk_a("up2", 1, 0, 1, 0, 0, 8'd0);
    smp(4'd4); smp(4'd6);
    chk_a("up2.hold", 1, 0, 1, 0, 0, 8'd0);

    // Down by one across the wrap
    do_reset();
    smp(4'd1); smp(4'd0); smp(4'd15); smp(4'd14);
    chk_a("dn1", 0, 1, 1, 0, 0, 8'd0);
    smp(4'd13);
    chk_a("dn1.hold", 0, 1, 1, 0, 0, 8'd0);

    // Locked up1, then a +2 jump
    do_reset();
    smp(4'd2); smp(4'd3); smp(4'd4); smp(4'd5);
    chk_a("jmp.lock", 0, 0, 1, 0, 0, 8'd0);
    smp(4'd7);
    if (MC_EN) chk_a("jmp", 1, 0, 1, 0, 1, 8'd0);
    else       chk_a("jmp", 0, 0, 0, 1, 0, 8'd1);
    idle(1);
    chk("jmp.err_drop", 32'(a_err), 32'd0);
    chk("jmp.mc_drop",  32'(a_mc),  32'd0);
    smp(4'd8); smp(4'd9);
    chk("relock.pre", 32'(a_locked), 32'(MC_EN));
    smp(4'd10);
    chk_a("relock", 0, 0, 1, 0, 0, MC_EN ? 8'd0 : 8'd1);

    // Five lock/error cycles, with idle gaps inside each relock
    do_reset();
    smp(4'd0); smp(4'd1); smp(4'd2); smp(4'd3);
    p = 4'd3;
    for (int i = 0; i < 5; i++) begin
      smp(p);  // zero delta is always illegal
      chk_a("sat.err", 0, 0, 0, 1, 0, 8'(i + 1));
      chk("sat.b_cnt", 32'(b_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      smp(p + 4'd1);
      idle(2);
      chk("sat.gap", 32'(a_locked), 32'd0);
      smp(p + 4'd2);
      smp(p + 4'd3);
      idle(3);
      chk_a("sat.relock", 0, 0, 1, 0, 0, 8'(i + 1));
      chk("sat.b_locked", 32'(b_locked), 32'd1);
      p = p + 4'd3;
    end

    // Async reset while acquiring
    smp(p);
    chk("acq.a_cnt", 32'(a_cnt), 32'd6);
    chk("acq.b_cnt", 32'(b_cnt), 32'd3);
    smp(p + 4'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk_a("arst", 0, 0, 0, 0, 0, 8'd0);
    chk("arst.b_cnt", 32'(b_cnt), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    smp(4'd7); smp(4'd8); smp(4'd9);
    chk("post.pre", 32'(a_locked), 32'd0);
    smp(4'd10);
    chk_a("post", 0, 0, 1, 0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
